// File: rtl/uart_pkg.sv
// uart_pkg: definitions shared by the UART receive and transmit blocks.
//   uart_state_e : receiver FSM state encoding
//   DATA_BITS    : payload bits per frame
//   clks_per_bit : system clocks per serial bit (integer division)
package uart_pkg;

  localparam int DATA_BITS = 8;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4,
    ST_BREAK  = 3'd5
  } uart_state_e;

  function automatic int clks_per_bit(input int clk_hz, input int baud);
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/uart_sync2.sv
// uart_sync2: generic two-flop synchroniser for an asynchronous input.
//   clk   : destination clock
//   reset : synchronous active-high reset; both flops load RESET_VAL
//   d     : asynchronous input
//   q     : synchronised output (second flop)
module uart_sync2 #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1 asynchronous serial receiver with valid/ready output.
//   clk           : system clock
//   reset         : synchronous active-high reset
//   rx_pin        : asynchronous serial line, idles high
//   rx_data       : received byte, stable while rx_valid is high
//   rx_valid      : byte available, held until rx_ready accepts it
//   rx_ready      : consumer accept
//   rx_frame_err  : one-cycle pulse when the stop bit is sampled low
//   rx_overrun    : sticky, a byte completed while the previous one was pending
//   rx_parity_err : (UART_RX_PARITY_EN only) one-cycle pulse on bad even parity
//   rx_busy       : receiver is not idle
// Build option: define UART_RX_PARITY_EN to add an even-parity bit after the data.
//
// state  | meaning
// IDLE   | line idle, waiting for a falling edge on rx_s
// START  | counting to mid start bit to reject glitches
// DATA   | sampling 8 data bits at mid-bit, LSB first
// PARITY | sampling the even-parity bit (UART_RX_PARITY_EN only)
// STOP   | sampling the stop bit; deliver byte or flag framing error
// BREAK  | line held low after a framing error, wait for it to go high
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLK_HZ = 10_000_000,
  parameter int BAUD   = 115_200
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx_pin,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       rx_frame_err,
  output logic       rx_overrun,
`ifdef UART_RX_PARITY_EN
  output logic       rx_parity_err,
`endif
  output logic       rx_busy
);

  localparam int CLKS_PER_BIT = clks_per_bit(CLK_HZ, BAUD);
  localparam int CNT_W        = $clog2(CLKS_PER_BIT);
  localparam int IDX_W        = $clog2(DATA_BITS);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

  uart_state_e          state;
  logic [CNT_W-1:0]     cnt;
  logic [IDX_W-1:0]     idx;
  logic [DATA_BITS-1:0] shreg;
  logic                 rx_s;
`ifdef UART_RX_PARITY_EN
  logic                 par_bit;
`endif

  uart_sync2 #(.RESET_VAL(1'b1)) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (rx_pin),
    .q     (rx_s)
  );

  assign rx_busy = (state != ST_IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= ST_IDLE;
      cnt          <= '0;
      idx          <= '0;
      shreg        <= '0;
      rx_data      <= '0;
      rx_valid     <= 1'b0;
      rx_frame_err <= 1'b0;
      rx_overrun   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bit       <= 1'b0;
      rx_parity_err <= 1'b0;
`endif
    end else begin
      rx_frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      rx_parity_err <= 1'b0;
`endif
      // A load in STOP below overrides this clear, so an accept on the
      // same edge as a new byte keeps rx_valid high.
      if (rx_valid && rx_ready) rx_valid <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (!rx_s) begin
            state <= ST_START;
            cnt   <= '0;
          end
        end

        ST_START: begin
          if (cnt == CNT_HALF) begin
            cnt <= '0;
            idx <= '0;
            state <= rx_s ? ST_IDLE : ST_DATA;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        ST_DATA: begin
          if (cnt == CNT_LAST) begin
            cnt        <= '0;
            shreg[idx] <= rx_s;
            if (idx == IDX_LAST) begin
`ifdef UART_RX_PARITY_EN
              state <= ST_PARITY;
`else
              state <= ST_STOP;
`endif
            end else begin
              idx <= idx + 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

`ifdef UART_RX_PARITY_EN
        ST_PARITY: begin
          if (cnt == CNT_LAST) begin
            cnt     <= '0;
            par_bit <= rx_s;
            state   <= ST_STOP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
`endif

        ST_STOP: begin
          if (cnt == CNT_LAST) begin
            cnt <= '0;
`ifdef UART_RX_PARITY_EN
            rx_parity_err <= (par_bit != ^shreg);
`endif
            if (rx_s) begin
              state    <= ST_IDLE;
              rx_data  <= shreg;
              rx_valid <= 1'b1;
              if (rx_valid && !rx_ready) rx_overrun <= 1'b1;
            end else begin
              rx_frame_err <= 1'b1;
              state        <= ST_BREAK;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        ST_BREAK: begin
          if (rx_s) state <= ST_IDLE;
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed bench for uart_rx at 10 clocks per bit.
// Build option: define UART_RX_PARITY_EN to exercise the parity variant.
module tb_uart_rx;

  localparam int CPB = 10;
`ifdef UART_RX_PARITY_EN
  localparam int EXP_LAT = 107;
`else
  localparam int EXP_LAT = 97;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       rx_pin;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       rx_frame_err;
  logic       rx_overrun;
  logic       rx_busy;
`ifdef UART_RX_PARITY_EN
  logic       rx_parity_err;
`endif

  uart_rx #(.CLK_HZ(1_000_000), .BAUD(100_000)) dut (
    .clk          (clk),
    .reset        (reset),
    .rx_pin       (rx_pin),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_ready     (rx_ready),
    .rx_frame_err (rx_frame_err),
    .rx_overrun   (rx_overrun),
`ifdef UART_RX_PARITY_EN
    .rx_parity_err(rx_parity_err),
`endif
    .rx_busy      (rx_busy)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;
  int cyc     = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Observation: accepted bytes, error pulses, busy cycles, first valid.
  logic [7:0] got_q[$];
  int n_ferr = 0;
  int n_perr = 0;
  int n_busy = 0;
  int first_valid_cyc = -1;

  always @(negedge clk) begin
    if (!reset) begin
      if (rx_valid && rx_ready) got_q.push_back(rx_data);
      if (rx_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (rx_frame_err) n_ferr++;
      if (rx_busy) n_busy++;
`ifdef UART_RX_PARITY_EN
      if (rx_parity_err) n_perr++;
`endif
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    n_total++;
    if (act >= lo && act <= hi) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_obs();
    got_q.delete();
    n_ferr = 0;
    n_perr = 0;
    n_busy = 0;
    first_valid_cyc = -1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_bit, input logic par_bad);
    rx_pin = 1'b0;
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      rx_pin = d[i];
      tick(CPB);
    end
`ifdef UART_RX_PARITY_EN
    rx_pin = (^d) ^ par_bad;
    tick(CPB);
`else
    if (par_bad) $display("note: parity not built in");
`endif
    rx_pin = stop_bit;
    tick(CPB);
    rx_pin = 1'b1;
  endtask

  typedef struct {
    logic [7:0] data;
    int         gap;
  } frame_t;

  frame_t vec[3];

  initial begin
    int start_cyc;

    vec[0] = '{data: 8'h55, gap: 0};
    vec[1] = '{data: 8'h00, gap: 0};
    vec[2] = '{data: 8'hFF, gap: 0};

    reset = 1'b1;
    rx_pin = 1'b1;
    rx_ready = 1'b1;
    tick(3);
    check("reset_rx_data", rx_data, 8'h00);
    check("reset_rx_valid", rx_valid, 1'b0);
    check("reset_frame_err", rx_frame_err, 1'b0);
    check("reset_overrun", rx_overrun, 1'b0);
    check("reset_busy", rx_busy, 1'b0);
    reset = 1'b0;
    tick(5);

    // Table: back-to-back good frames; latency measured on the first.
    clear_obs();
    start_cyc = cyc + 1;
    for (int i = 0; i < 3; i++) begin
      send_frame(vec[i].data, 1'b1, 1'b0);
      tick(vec[i].gap);
    end
    tick(20);
    check_range("latency_0x55", first_valid_cyc - start_cyc, EXP_LAT - 1, EXP_LAT + 1);
    check("b2b_count", got_q.size(), 3);
    for (int i = 0; i < 3; i++)
      if (i < got_q.size()) check($sformatf("b2b_data%0d", i), got_q[i], vec[i].data);
    check("b2b_no_ferr", n_ferr, 0);
    check("b2b_no_perr", n_perr, 0);
    check("b2b_no_overrun", rx_overrun, 1'b0);
    check("b2b_idle", rx_busy, 1'b0);

    // Overrun: two frames with the consumer stalled.
    clear_obs();
    rx_ready = 1'b0;
    send_frame(8'hA5, 1'b1, 1'b0);
    send_frame(8'h3C, 1'b1, 1'b0);
    tick(10);
    check("ovr_valid_held", rx_valid, 1'b1);
    check("ovr_data", rx_data, 8'h3C);
    check("ovr_flag", rx_overrun, 1'b1);
    rx_ready = 1'b1;
    tick(5);
    check("ovr_valid_cleared", rx_valid, 1'b0);
    check("ovr_sticky", rx_overrun, 1'b1);
    check("ovr_accepted", got_q.size(), 1);

    // Start-bit glitch: 3 low cycles on an idle line.
    clear_obs();
    rx_pin = 1'b0;
    tick(3);
    rx_pin = 1'b1;
    tick(30);
    check_range("glitch_busy_cycles", n_busy, 1, 6);
    check("glitch_no_valid", got_q.size(), 0);
    check("glitch_no_ferr", n_ferr, 0);

    // Framing error with the line held low, then a good frame.
    clear_obs();
    send_frame(8'h81, 1'b0, 1'b0);
    rx_pin = 1'b0;
    tick(20);
    rx_pin = 1'b1;
    tick(15);
    check("ferr_pulses", n_ferr, 1);
    check("ferr_no_valid", got_q.size(), 0);
    send_frame(8'h12, 1'b1, 1'b0);
    tick(15);
    check("ferr_next_count", got_q.size(), 1);
    if (got_q.size() > 0) check("ferr_next_data", got_q[0], 8'h12);
    check("ferr_no_more", n_ferr, 1);

    // Reset during data bit 4 of 0x77, then a clean 0xC3.
    clear_obs();
    rx_pin = 1'b0;
    tick(CPB);
    for (int i = 0; i < 4; i++) begin
      rx_pin = (i == 3) ? 1'b0 : 1'b1;
      tick(CPB);
    end
    rx_pin = 1'b1;
    tick(5);
    reset = 1'b1;
    tick(1);
    check("rst_mid_valid", rx_valid, 1'b0);
    check("rst_mid_data", rx_data, 8'h00);
    check("rst_mid_busy", rx_busy, 1'b0);
    check("rst_mid_overrun", rx_overrun, 1'b0);
    check("rst_mid_ferr", rx_frame_err, 1'b0);
    tick(2);
    reset = 1'b0;
    tick(30);
    check("rst_no_partial", got_q.size(), 0);
    send_frame(8'hC3, 1'b1, 1'b0);
    tick(15);
    check("rst_next_count", got_q.size(), 1);
    check("rst_next_data", rx_data, 8'hC3);
    check("rst_next_ferr", n_ferr, 0);

`ifdef UART_RX_PARITY_EN
    clear_obs();
    send_frame(8'h55, 1'b1, 1'b1);
    tick(15);
    check("par_err_pulses", n_perr, 1);
    check("par_err_count", got_q.size(), 1);
    check("par_err_data", rx_data, 8'h55);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
